// File: rtl/serial_subtractor_if.sv
// Request/result bundle for the bit-serial subtractor: operands and start in,
// registered difference, flags and status out.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic [WIDTH-1:0] d;
  logic             bout;
  logic             ovf;
  logic             busy;
  logic             done;

  modport master (
    output start, a, b, bin,
    input  d, bout, ovf, busy, done
  );

  modport slave (
    input  start, a, b, bin,
    output d, bout, ovf, busy, done
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: one full-subtractor stage per clock, LSB first,
// WIDTH clocks per operation, results held until the next completion.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  serial_subtractor_if.slave   bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             br_q, br_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             bout_q, bout_d;
  logic             ovf_q, ovf_d;

  logic diff_bit;
  logic br_nxt;

  assign diff_bit = a_sh_q[0] ^ b_sh_q[0] ^ br_q;
  assign br_nxt   = (~a_sh_q[0] & b_sh_q[0]) | (~(a_sh_q[0] ^ b_sh_q[0]) & br_q);

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    res_d   = res_q;
    br_d    = br_q;
    cnt_d   = cnt_q;
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    d_d     = d_q;
    bout_d  = bout_q;
    ovf_d   = ovf_q;

    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          a_sh_d  = bus.a;
          b_sh_d  = bus.b;
          br_d    = bus.bin;
          res_d   = '0;
          cnt_d   = '0;
          a_msb_d = bus.a[WIDTH-1];
          b_msb_d = bus.b[WIDTH-1];
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        br_d   = br_nxt;
        res_d  = {diff_bit, res_q[WIDTH-1:1]};
        cnt_d  = cnt_q + CW'(1);
        // Last bit: publish the shifted-in result directly so d is valid in DONE.
        if (cnt_q == CW'(WIDTH - 1)) begin
          d_d     = {diff_bit, res_q[WIDTH-1:1]};
          bout_d  = br_nxt;
          ovf_d   = (a_msb_q != b_msb_q) & (diff_bit != a_msb_q);
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      d_q     <= '0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      res_q   <= res_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      d_q     <= d_d;
      bout_q  <= bout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.d    = d_q;
  assign bus.bout = bout_q;
  assign bus.ovf  = ovf_q;
  assign bus.busy = (state_q == RUN);
  assign bus.done = (state_q == DONE);
endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for the serial subtractor: WIDTH=8 vectors, ignore/abort
// scenarios, and an exhaustive back-to-back sweep of a WIDTH=4 instance.
module tb_serial_subtractor;
  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  serial_subtractor_if #(.WIDTH(8)) bus8 ();
  serial_subtractor_if #(.WIDTH(4)) bus4 ();

  serial_subtractor #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8.slave));
  serial_subtractor #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Launches one WIDTH=8 operation and observes 12 edges after the accept edge.
  // If inject > 0, a stray start pulse is driven so it is sampled at edge inject+1.
  task automatic run_op(input logic [7:0] av, input logic [7:0] bv, input logic binv,
                        input int inject, output int first, output int ndone,
                        output logic busy_ok, output logic [7:0] dv,
                        output logic bo, output logic ov);
    @(negedge clk);
    bus8.start = 1'b1; bus8.a = av; bus8.b = bv; bus8.bin = binv;
    @(posedge clk);
    #1;
    bus8.start = 1'b0; bus8.a = ~av; bus8.b = ~bv; bus8.bin = ~binv;
    first = -1; ndone = 0; busy_ok = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      @(posedge clk);
      #1 bus8.start = 1'b0;
      @(negedge clk);
      if (bus8.done === 1'b1) begin
        if (first < 0) first = n;
        ndone++;
      end
      if ((n < 8) != (bus8.busy === 1'b1)) busy_ok = 1'b0;
      if (n == inject) begin
        bus8.start = 1'b1; bus8.a = 8'h00; bus8.b = 8'h01; bus8.bin = 1'b0;
      end
    end
    dv = bus8.d; bo = bus8.bout; ov = bus8.ovf;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus8.start = 1'b0; bus8.a = '0; bus8.b = '0; bus8.bin = 1'b0;
    bus4.start = 1'b0; bus4.a = '0; bus4.b = '0; bus4.bin = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus8.d, bus8.bout, bus8.ovf, bus8.busy, bus8.done} !== 12'h000) begin
      errors++;
      $display("FAIL reset8: got d=%h bout=%b ovf=%b busy=%b done=%b, want all 0",
               bus8.d, bus8.bout, bus8.ovf, bus8.busy, bus8.done);
    end
    checks++;
    if ({bus4.d, bus4.bout, bus4.ovf, bus4.busy, bus4.done} !== 8'h00) begin
      errors++;
      $display("FAIL reset4: got d=%h bout=%b ovf=%b busy=%b done=%b, want all 0",
               bus4.d, bus4.bout, bus4.ovf, bus4.busy, bus4.done);
    end
    rst_n = 1'b1;
    $display("reset: checked outputs cleared");
  endtask

  task automatic test_vectors();
    logic [7:0] va [5] = '{8'h05, 8'h00, 8'h10, 8'h80, 8'h7F};
    logic [7:0] vb [5] = '{8'h03, 8'h01, 8'h10, 8'h01, 8'hFF};
    logic       vc [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [7:0] ed [5] = '{8'h02, 8'hFF, 8'hFF, 8'h7F, 8'h80};
    logic       eb [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic       eo [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    int first, ndone;
    logic busy_ok, bo, ov;
    logic [7:0] dv;
    for (int i = 0; i < 5; i++) begin
      run_op(va[i], vb[i], vc[i], 0, first, ndone, busy_ok, dv, bo, ov);
      checks++;
      if (first != 8 || ndone != 1) begin
        errors++;
        $display("FAIL vec%0d_latency: got first_done=%0d count=%0d, want 8 and 1", i, first, ndone);
      end
      checks++;
      if (!busy_ok) begin
        errors++;
        $display("FAIL vec%0d_busy: got busy profile wrong, want high edges 0..7 only", i);
      end
      checks++;
      if ({dv, bo, ov} !== {ed[i], eb[i], eo[i]}) begin
        errors++;
        $display("FAIL vec%0d_result: got d=%h bout=%b ovf=%b, want d=%h bout=%b ovf=%b",
                 i, dv, bo, ov, ed[i], eb[i], eo[i]);
      end
      $display("vec%0d: a=%h b=%h bin=%b -> d=%h bout=%b ovf=%b done@%0d",
               i, va[i], vb[i], vc[i], dv, bo, ov, first);
    end
  endtask

  task automatic test_ignore_start();
    int first, ndone;
    logic busy_ok, bo, ov;
    logic [7:0] dv;
    run_op(8'h09, 8'h04, 1'b0, 3, first, ndone, busy_ok, dv, bo, ov);
    checks++;
    if (first != 8 || ndone != 1) begin
      errors++;
      $display("FAIL ignore_done: got first_done=%0d count=%0d, want 8 and 1", first, ndone);
    end
    checks++;
    if ({dv, bo, ov} !== {8'h05, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL ignore_result: got d=%h bout=%b ovf=%b, want d=05 bout=0 ovf=0", dv, bo, ov);
    end
    $display("ignore: start during RUN -> d=%h dones=%0d", dv, ndone);
  endtask

  task automatic test_reset_mid_run();
    int first, ndone, spurious;
    logic busy_ok, bo, ov;
    logic [7:0] dv;
    @(negedge clk);
    bus8.start = 1'b1; bus8.a = 8'hC3; bus8.b = 8'h11; bus8.bin = 1'b1;
    @(posedge clk);
    #1 bus8.start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus8.d, bus8.bout, bus8.ovf, bus8.busy, bus8.done} !== 12'h000) begin
      errors++;
      $display("FAIL abort_clear: got d=%h bout=%b ovf=%b busy=%b done=%b, want all 0",
               bus8.d, bus8.bout, bus8.ovf, bus8.busy, bus8.done);
    end
    spurious = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (bus8.done !== 1'b0 || bus8.busy !== 1'b0) spurious++;
    end
    checks++;
    if (spurious != 0) begin
      errors++;
      $display("FAIL abort_no_done: got %0d cycles with done/busy high, want 0", spurious);
    end
    run_op(8'h20, 8'h01, 1'b1, 0, first, ndone, busy_ok, dv, bo, ov);
    checks++;
    if (first != 8 || ndone != 1 || {dv, bo, ov} !== {8'h1E, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL after_abort: got d=%h bout=%b ovf=%b done@%0d x%0d, want d=1e bout=0 ovf=0 done@8 x1",
               dv, bo, ov, first, ndone);
    end
    $display("abort: mid-run reset, then a=20 b=01 bin=1 -> d=%h", dv);
  endtask

  task automatic test_back_to_back();
    int a_v, b_v, c_v, nxt, diff, early, bad;
    logic [3:0] ed;
    logic eb, eo;
    early = 0; bad = 0;
    @(negedge clk);
    bus4.start = 1'b1; bus4.a = 4'd0; bus4.b = 4'd0; bus4.bin = 1'b0;
    @(posedge clk);
    for (int k = 0; k < 512; k++) begin
      a_v = k / 32; b_v = (k / 2) % 16; c_v = k % 2;
      #1;
      nxt = k + 1;
      if (nxt < 512) begin
        bus4.a = 4'(nxt / 32); bus4.b = 4'((nxt / 2) % 16); bus4.bin = 1'(nxt % 2);
      end else begin
        bus4.start = 1'b0;
      end
      for (int n = 1; n < 4; n++) begin
        @(posedge clk);
        @(negedge clk);
        if (bus4.done !== 1'b0 || bus4.busy !== 1'b1) early++;
      end
      @(posedge clk);
      @(negedge clk);
      diff = a_v - b_v - c_v;
      ed = 4'(diff & 15);
      eb = (diff < 0);
      eo = ((a_v >= 8) != (b_v >= 8)) && (ed[3] != (a_v >= 8));
      checks++;
      if ({bus4.done, bus4.busy, bus4.d, bus4.bout, bus4.ovf} !== {1'b1, 1'b0, ed, eb, eo}) begin
        errors++; bad++;
        $display("FAIL b2b_case%0d a=%0d b=%0d bin=%0d: got done=%b busy=%b d=%h bout=%b ovf=%b, want done=1 busy=0 d=%h bout=%b ovf=%b",
                 k, a_v, b_v, c_v, bus4.done, bus4.busy, bus4.d, bus4.bout, bus4.ovf, ed, eb, eo);
      end
      @(posedge clk);
    end
    checks++;
    if (early != 0) begin
      errors++;
      $display("FAIL b2b_timing: got %0d run cycles with wrong done/busy, want 0", early);
    end
    $display("b2b: 512 WIDTH=4 cases, %0d result errors, %0d timing errors", bad, early);
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_ignore_start();
    test_reset_mid_run();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
